// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase sequencer for the RV32I core: FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
// Owns the shared memory port; strobes are decoded from the phase plus the class latched in DECODE.
module cpu_phase_sequencer #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           code,
  input  logic [2:0]           funct3,
  input  logic                 EQ,
  input  logic                 LS,
  input  logic                 LU,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 addr_sel,
  output logic                 insn_we,
  output logic                 rd_we,
  output logic                 pc_we,
  output logic                 pc_next_sel,
  output logic                 pc_alu_sel,
  output logic [2:0]           phase,
  output logic                 halted,
  output logic [INSTRET_W-1:0] instret
);

  localparam int unsigned CODE_W = 10;
  localparam int unsigned F3_W   = 3;

  localparam int unsigned C_LUI    = 0;
  localparam int unsigned C_AUIPC  = 1;
  localparam int unsigned C_JAL    = 2;
  localparam int unsigned C_JALR   = 3;
  localparam int unsigned C_BRANCH = 4;
  localparam int unsigned C_LOAD   = 5;
  localparam int unsigned C_STORE  = 6;
  localparam int unsigned C_OPIMM  = 7;
  localparam int unsigned C_OP     = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_TRAP      = 3'd6
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [F3_W-1:0]       f3_q;
  logic                  is_auipc_q;
  logic                  is_jal_q;
  logic                  is_jalr_q;
  logic                  is_branch_q;
  logic                  is_load_q;
  logic                  is_store_q;
  logic                  writes_rd_q;
  logic                  taken_q;
  logic                  taken_c;
  logic                  onehot_c;
  logic                  bad_branch_c;
  logic                  legal_c;
  logic [INSTRET_W-1:0]  instret_q;

  // Legality: exactly one class bit, and no branch with the reserved funct3 010/011.
  always_comb begin
    onehot_c     = (code != '0) && ((code & (code - CODE_W'(1))) == '0);
    bad_branch_c = code[C_BRANCH] && (funct3[2:1] == 2'b01);
    legal_c      = onehot_c && !bad_branch_c;
  end

  // Branch condition from the latched funct3 and the live ALU flags.
  always_comb begin
    taken_c = 1'b0;
    case (f3_q)
      3'b000:  taken_c = EQ;
      3'b001:  taken_c = !EQ;
      3'b100:  taken_c = LS;
      3'b101:  taken_c = !LS;
      3'b110:  taken_c = LU;
      3'b111:  taken_c = !LU;
      default: taken_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction class captured once in DECODE so later phases do not depend on the IR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q        <= '0;
      is_auipc_q  <= 1'b0;
      is_jal_q    <= 1'b0;
      is_jalr_q   <= 1'b0;
      is_branch_q <= 1'b0;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      writes_rd_q <= 1'b0;
    end else if (state_q == ST_DECODE) begin
      f3_q        <= funct3;
      is_auipc_q  <= code[C_AUIPC];
      is_jal_q    <= code[C_JAL];
      is_jalr_q   <= code[C_JALR];
      is_branch_q <= code[C_BRANCH];
      is_load_q   <= code[C_LOAD];
      is_store_q  <= code[C_STORE];
      writes_rd_q <= code[C_LUI] | code[C_AUIPC] | code[C_JAL] | code[C_JALR] |
                     code[C_LOAD] | code[C_OPIMM] | code[C_OP];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q <= 1'b0;
    end else if (state_q == ST_EXECUTE) begin
      taken_q <= is_branch_q & taken_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (state_q == ST_WRITEBACK) begin
      instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  // Next state and Moore-decoded strobes; insn_we alone is qualified by mem_ack.
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    addr_sel    = 1'b0;
    insn_we     = 1'b0;
    rd_we       = 1'b0;
    pc_we       = 1'b0;
    pc_next_sel = 1'b0;
    pc_alu_sel  = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        insn_we = mem_ack;
        if (mem_ack) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = legal_c ? ST_EXECUTE : ST_TRAP;
      ST_EXECUTE: begin
        pc_alu_sel = is_auipc_q | is_jal_q;
        state_d    = (is_load_q | is_store_q) ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = is_store_q;
        if (mem_ack) state_d = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        pc_we       = 1'b1;
        rd_we       = writes_rd_q;
        pc_next_sel = is_jal_q | is_jalr_q | (is_branch_q & taken_q);
        pc_alu_sel  = is_branch_q | is_jal_q;
        state_d     = ST_FETCH;
      end
      ST_TRAP: halted = 1'b1;
      default: state_d = ST_IDLE;
    endcase
  end

  assign phase   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Bench for cpu_phase_sequencer: directed vector table, hand-written reset corner cases and
// randomized instructions checked cycle by cycle against a per-instruction trace model.
module tb_cpu_phase_sequencer;

  localparam int unsigned IW       = 4;
  localparam int          TRAP_CYC = 20;

  logic          clk;
  logic          rst_n;
  logic [9:0]    code;
  logic [2:0]    funct3;
  logic          EQ, LS, LU;
  logic          mem_ack;
  logic          mem_req, mem_we, addr_sel, insn_we, rd_we, pc_we;
  logic          pc_next_sel, pc_alu_sel, halted;
  logic [2:0]    phase;
  logic [IW-1:0] instret;

  cpu_phase_sequencer #(.INSTRET_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .code(code), .funct3(funct3),
    .EQ(EQ), .LS(LS), .LU(LU), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .insn_we(insn_we),
    .rd_we(rd_we), .pc_we(pc_we), .pc_next_sel(pc_next_sel), .pc_alu_sel(pc_alu_sel),
    .phase(phase), .halted(halted), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] phase;
    logic       mem_req, mem_we, addr_sel, insn_we, rd_we, pc_we, pc_next_sel, pc_alu_sel, halted;
  } obs_t;

  typedef struct {
    logic ack;
    logic eq, ls, lu;
    logic rand_code;
    obs_t exp;
  } cyc_t;

  typedef struct {
    logic [9:0] code;
    logic [2:0] f3;
    logic       eq, ls, lu;
    int         fw, mw;
    int         exp_cycles;
    logic       exp_rd, exp_nsel, exp_trap;
  } vec_t;

  cyc_t          trace[$];
  vec_t          vecs[$];
  logic [9:0]    cur_code;
  logic [2:0]    cur_f3;
  logic          model_legal;
  logic [IW-1:0] exp_instret;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.phase = phase; o.mem_req = mem_req; o.mem_we = mem_we; o.addr_sel = addr_sel;
    o.insn_we = insn_we; o.rd_we = rd_we; o.pc_we = pc_we; o.pc_next_sel = pc_next_sel;
    o.pc_alu_sel = pc_alu_sel; o.halted = halted;
    return o;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, ls, lu);
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return ls;
      3'd5: return !ls;
      3'd6: return lu;
      3'd7: return !lu;
      default: return 1'b0;
    endcase
  endfunction

  // Expected cycle-by-cycle trace of one instruction, starting in FETCH.
  function automatic void build(input logic [9:0] c, input logic [2:0] f3,
                                input logic eq, ls, lu, input int fw, mw);
    cyc_t r;
    logic is_mem;
    trace.delete();
    cur_code = c;
    cur_f3   = f3;
    model_legal = ($countones(c) == 1) && !(c[4] && (f3 == 3'd2 || f3 == 3'd3));
    r.eq = eq; r.ls = ls; r.lu = lu;
    for (int i = 0; i <= fw; i++) begin
      r.exp = '0; r.exp.phase = 3'd1; r.exp.mem_req = 1'b1;
      r.ack = (i == fw); r.exp.insn_we = r.ack; r.rand_code = 1'b1;
      trace.push_back(r);
    end
    r.rand_code = 1'b0; r.ack = 1'b0;
    r.exp = '0; r.exp.phase = 3'd2;
    trace.push_back(r);
    if (!model_legal) begin
      for (int i = 0; i < TRAP_CYC; i++) begin
        r.exp = '0; r.exp.phase = 3'd6; r.exp.halted = 1'b1;
        trace.push_back(r);
      end
      return;
    end
    r.exp = '0; r.exp.phase = 3'd3; r.exp.pc_alu_sel = c[1] | c[2];
    trace.push_back(r);
    is_mem = c[5] | c[6];
    if (is_mem) begin
      for (int i = 0; i <= mw; i++) begin
        r.exp = '0; r.exp.phase = 3'd4; r.exp.mem_req = 1'b1; r.exp.addr_sel = 1'b1;
        r.exp.mem_we = c[6]; r.ack = (i == mw);
        trace.push_back(r);
      end
    end
    r.ack = 1'b0;
    r.exp = '0; r.exp.phase = 3'd5; r.exp.pc_we = 1'b1;
    r.exp.rd_we = !(c[4] | c[6] | c[9]);
    r.exp.pc_next_sel = c[2] | c[3] | (c[4] & branch_taken(f3, eq, ls, lu));
    r.exp.pc_alu_sel = c[4] | c[2];
    trace.push_back(r);
  endfunction

  // Drive the trace, with noise on ack/flags/code wherever the DUT must ignore them.
  task automatic run_trace(input string tag, output int wb_cycles, output logic wb_rd,
                           output logic wb_nsel, output logic trapped);
    obs_t got;
    wb_cycles = 0; wb_rd = 1'b0; wb_nsel = 1'b0; trapped = 1'b0;
    foreach (trace[i]) begin
      mem_ack = trace[i].exp.mem_req ? trace[i].ack : 1'($urandom);
      if (trace[i].exp.phase == 3'd3) {EQ, LS, LU} = {trace[i].eq, trace[i].ls, trace[i].lu};
      else {EQ, LS, LU} = 3'($urandom);
      code   = trace[i].rand_code ? 10'($urandom) : cur_code;
      funct3 = trace[i].rand_code ? 3'($urandom) : cur_f3;
      @(negedge clk);
      got = sample();
      chk($sformatf("%s_obs[%0d]", tag, i), 32'(got), 32'(trace[i].exp));
      chk($sformatf("%s_instret[%0d]", tag, i), 32'(instret), 32'(exp_instret));
      if (got.phase == 3'd5 && wb_cycles == 0) begin
        wb_cycles = i + 1; wb_rd = got.rd_we; wb_nsel = got.pc_next_sel;
      end
      if (got.phase == 3'd6) trapped = 1'b1;
      @(posedge clk); #1;
      if (trace[i].exp.phase == 3'd5) exp_instret = exp_instret + 1'b1;
    end
  endtask

  task automatic release_reset();
    mem_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_release", 32'(phase), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; mem_ack = 1'b0;
    #1;
    chk("reset_outputs", 32'(sample()), 32'd0);
    chk("reset_instret", 32'(instret), 32'd0);
    exp_instret = '0;
    release_reset();
  endtask

  int         cyc;
  logic       rd, nsel, trp;
  logic [9:0] rc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; code = '0; funct3 = '0; {EQ, LS, LU} = 3'b0; mem_ack = 1'b0;
    exp_instret = '0;
    #2;
    do_reset();

    //            code           f3    eq ls lu fw mw cyc rd nsel trap
    vecs.push_back('{10'b0100000000, 3'd0, 0, 0, 0, 0, 0, 4, 1, 0, 0}); // OP
    vecs.push_back('{10'b0000100000, 3'd2, 0, 0, 0, 0, 2, 7, 1, 0, 0}); // LOAD, 2 waits
    vecs.push_back('{10'b0000010000, 3'd0, 1, 0, 0, 0, 0, 4, 0, 1, 0}); // BEQ taken
    vecs.push_back('{10'b0000010000, 3'd1, 1, 0, 0, 0, 0, 4, 0, 0, 0}); // BNE not taken
    vecs.push_back('{10'b0001000000, 3'd2, 0, 0, 0, 1, 1, 7, 0, 0, 0}); // STORE
    vecs.push_back('{10'b0000000100, 3'd0, 0, 0, 0, 2, 0, 6, 1, 1, 0}); // JAL, 2 fetch waits
    vecs.push_back('{10'b0000001000, 3'd0, 0, 0, 0, 0, 0, 4, 1, 1, 0}); // JALR
    vecs.push_back('{10'b0000000001, 3'd0, 0, 0, 0, 0, 0, 4, 1, 0, 0}); // LUI
    vecs.push_back('{10'b0000000010, 3'd0, 0, 0, 0, 0, 0, 4, 1, 0, 0}); // AUIPC
    vecs.push_back('{10'b1000000000, 3'd0, 0, 0, 0, 0, 0, 4, 0, 0, 0}); // FENCE/SYSTEM
    vecs.push_back('{10'b0000010000, 3'd5, 0, 0, 0, 0, 0, 4, 0, 1, 0}); // BGE taken
    vecs.push_back('{10'b0000010000, 3'd6, 0, 0, 0, 0, 0, 4, 0, 0, 0}); // BLTU not taken
    vecs.push_back('{10'b0000110000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1}); // two class bits
    vecs.push_back('{10'b0000010000, 3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 1}); // BRANCH f3=010
    vecs.push_back('{10'b0000000000, 3'd0, 0, 0, 0, 1, 0, 0, 0, 0, 1}); // no class bit

    foreach (vecs[i]) begin
      build(vecs[i].code, vecs[i].f3, vecs[i].eq, vecs[i].ls, vecs[i].lu, vecs[i].fw, vecs[i].mw);
      run_trace($sformatf("vec%0d", i), cyc, rd, nsel, trp);
      chk($sformatf("vec%0d_trap", i), 32'(trp), 32'(vecs[i].exp_trap));
      if (!vecs[i].exp_trap) begin
        chk($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
        chk($sformatf("vec%0d_rd_we", i), 32'(rd), 32'(vecs[i].exp_rd));
        chk($sformatf("vec%0d_pc_next_sel", i), 32'(nsel), 32'(vecs[i].exp_nsel));
      end
      if (trp || vecs[i].exp_trap) do_reset();
    end

    // Reset mid-MEMORY with ack high: everything drops at once, instret clears.
    do_reset();
    build(10'b0100000000, 3'd0, 0, 0, 0, 0, 0);
    run_trace("pre_rst0", cyc, rd, nsel, trp);
    run_trace("pre_rst1", cyc, rd, nsel, trp);
    code = 10'b0000100000; funct3 = 3'd2; {EQ, LS, LU} = 3'b0;
    mem_ack = 1'b1;
    @(negedge clk); chk("mid_mem_fetch_phase", 32'(phase), 32'd1);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk); chk("mid_mem_decode_phase", 32'(phase), 32'd2);
    @(posedge clk); #1;
    @(negedge clk); chk("mid_mem_exec_phase", 32'(phase), 32'd3);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_mem_phase", 32'(phase), 32'd4);
    chk("mid_mem_req", 32'({mem_req, addr_sel, mem_we}), 32'b110);
    chk("mid_mem_instret", 32'(instret), 32'd2);
    mem_ack = 1'b1; rst_n = 1'b0;
    #1;
    chk("mid_mem_rst_outputs", 32'(sample()), 32'd0);
    chk("mid_mem_rst_instret", 32'(instret), 32'd0);
    exp_instret = '0;
    @(posedge clk); #1;
    chk("mid_mem_rst_held", 32'(sample()), 32'd0);
    release_reset();

    // Reset mid-FETCH with ack high: no instruction-register strobe.
    @(negedge clk);
    chk("mid_fetch_req", 32'({phase, mem_req}), 32'({3'd1, 1'b1}));
    mem_ack = 1'b1; rst_n = 1'b0;
    #1;
    chk("mid_fetch_rst_outputs", 32'(sample()), 32'd0);
    release_reset();
    build(10'b0100000000, 3'd0, 0, 0, 0, 0, 0);
    run_trace("post_rst", cyc, rd, nsel, trp);
    chk("post_rst_instret", 32'(instret), 32'd1);

    // Randomized instructions; instret (4 bits here) wraps along the way.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 19) == 0) rc = 10'($urandom);
      else rc = 10'b1 << $urandom_range(0, 9);
      build(rc, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_trace($sformatf("rnd%0d", n), cyc, rd, nsel, trp);
      if (trp || !model_legal) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_phase_sequencer.md
# cpu_phase_sequencer

Multi-cycle control sequencer for the RV32I core. Steps each instruction through FETCH, DECODE, EXECUTE, optional MEMORY and WRITEBACK, and owns the shared memory port through a req/ack handshake. It drives the per-phase register and PC write enables and the PC/ALU/address selects. Sits between the opcode-class decoder (`code`, `funct3`) and the datapath (register file, PC register, instruction register, ALU, memory interface).

## Interface
- `INSTRET_W`, 32, width of the retired-instruction counter.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `code`  in  10  one-hot opcode class from the instruction register: [0] LUI, [1] AUIPC, [2] JAL, [3] JALR, [4] BRANCH, [5] LOAD, [6] STORE, [7] OP-IMM, [8] OP, [9] FENCE/SYSTEM (treated as NOP).
- `funct3`  in  3  insn[14:12].
- `EQ`, `LS`, `LU`  in  1 each  ALU compare flags (equal, less signed, less unsigned); valid during EXECUTE.
- `mem_ack`  in  1  memory completes the current request.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  store request; valid only with `mem_req`.
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `insn_we`  out  1  instruction-register load strobe.
- `rd_we`  out  1  register-file write strobe.
- `pc_we`  out  1  PC load strobe.
- `pc_next_sel`  out  1  next PC: 0 = PC+4, 1 = ALU result.
- `pc_alu_sel`  out  1  ALU operand A: 0 = rs1, 1 = PC.
- `phase`  out  3  current state encoding.
- `halted`  out  1  illegal instruction trapped.
- `instret`  out  INSTRET_W  retired-instruction count.

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6.
- IDLE: entered on reset. Goes to FETCH on the first clock edge with `rst_n` high.
- FETCH: `mem_req`=1, `addr_sel`=0, `mem_we`=0. On the cycle with `mem_ack`=1, `insn_we`=1 for that cycle only, then go to DECODE.
- DECODE: one cycle. Legality check on `code`/`funct3`:
  - `code` not exactly one-hot goes to TRAP.
  - BRANCH with `funct3` 010 or 011 goes to TRAP.
  - Otherwise go to EXECUTE.
- EXECUTE: one cycle.
  - `pc_alu_sel`=1 for AUIPC and JAL, else 0.
  - For BRANCH, register `taken` at the end of the cycle: 000 EQ, 001 !EQ, 100 LS, 101 !LS, 110 LU, 111 !LU.
  - LOAD/STORE go to MEMORY; all others go to WRITEBACK.
- MEMORY: `mem_req`=1, `addr_sel`=1, `mem_we`=1 for STORE. Held stable until `mem_ack`=1, then go to WRITEBACK.
- WRITEBACK: one cycle.
  - `pc_we`=1 for every class.
  - `rd_we`=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP. `rd_we`=0 for BRANCH, STORE, FENCE/SYSTEM.
  - `pc_next_sel`=1 for JAL, JALR, and BRANCH with `taken`=1, else 0.
  - `pc_alu_sel`=1 for BRANCH and JAL, so the ALU computes PC+imm. For JALR it is 0 (rs1+imm).
  - `instret` increments by 1, wrapping modulo 2^INSTRET_W.
  - Next state is FETCH.
- TRAP: `halted`=1. All strobes and `mem_req` are 0. Stays in TRAP until reset.
- Outputs are Moore-decoded from state plus the latched instruction class. Exception: `insn_we` is `mem_ack`-qualified in FETCH.

## Timing
- Reset (async assert) drives the block to these values immediately, with no clock needed:
  - `phase`=IDLE, `instret`=0, `taken`=0.
  - All outputs 0, including `halted`.
- Handshake:
  - `mem_ack` is sampled only while `mem_req`=1. An ack with req low is ignored.
  - An ack in the first cycle of a request is legal: zero wait states.
  - `mem_req`, `mem_we`, `addr_sel` stay constant from assertion until the ack cycle inclusive. `mem_req` drops the cycle after the ack.
- Latency with zero-wait memory:
  - Non-memory instruction: 4 cycles (F, D, E, W).
  - LOAD/STORE: 5 cycles.
  - Each wait state adds one cycle.
- `instret` updates on the edge that ends WRITEBACK.
- `taken` is held from EXECUTE through WRITEBACK. Flags are not sampled in any other state.
- Reset mid-MEMORY or mid-FETCH: `mem_req` deasserts asynchronously and no write strobe is issued. The pending ack is discarded.

## Test plan
- OP (`code`=0100000000), ack in the same cycle as req:
  - Phases 1, 2, 3, 5 on consecutive cycles.
  - `rd_we`=1, `pc_we`=1, `pc_next_sel`=0 in WRITEBACK.
  - `instret` 0→1.
- LOAD (`code`=0000100000), ack after 2 wait cycles in MEMORY:
  - `mem_req`=1, `addr_sel`=1, `mem_we`=0 for 3 cycles.
  - `rd_we`=1 in WRITEBACK.
  - Total 7 cycles.
- BEQ taken (`code`=0000010000, `funct3`=000, EQ=1 in EXECUTE):
  - WRITEBACK: `pc_next_sel`=1, `pc_alu_sel`=1, `rd_we`=0.
  - Repeat with BNE, EQ=1: `pc_next_sel`=0.
- STORE (`code`=0001000000): `mem_we`=1 only while `mem_req`=1 in MEMORY, and `rd_we`=0 in WRITEBACK.
- Illegal instructions:
  - `code`=0000110000 → TRAP the cycle after DECODE.
  - Separately, BRANCH with `funct3`=010 → TRAP.
  - In both cases `halted`=1 and all strobes stay 0 for 20 cycles, with `instret` unchanged.
- Reset mid-operation: assert `rst_n`=0 mid-MEMORY with `mem_ack` high.
  - Same instant: `mem_req`=0, `phase`=0, `instret`=0.
  - After release: FETCH on the next edge.
